// File: rtl/aes_iter_core.sv
// Iterative AES-128/192/256 block engine: one round per clock, optional inverse cipher,
// valid/ready handshake on both sides, round keys taken from a 15 x 128-bit expanded key.
module aes_iter_core #(
  parameter int ENABLE_DEC = 1,
  parameter int KEY_W      = 1920
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [127:0]     i_data,
  input  logic [3:0]       NR,
  input  logic             i_decrypt,
  input  logic [KEY_W-1:0] expanded_key,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [127:0]     o_data,
  output logic             o_bad_nr
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ROUND = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc ^= p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    return gf_inv(rotl(y, 1) ^ rotl(y, 3) ^ rotl(y, 6) ^ 8'h05);
  endfunction

  // State byte r+4c lives at bits [127-8(r+4c) -: 8].
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = inv_sbox(s[127-8*(r+4*((c-r+4)%4)) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = gf_mul(s[127-8*(r+4*c) -: 8], 8'h0e)
                              ^ gf_mul(s[127-8*((r+1)%4+4*c) -: 8], 8'h0b)
                              ^ gf_mul(s[127-8*((r+2)%4+4*c) -: 8], 8'h0d)
                              ^ gf_mul(s[127-8*((r+3)%4+4*c) -: 8], 8'h09);
    return o;
  endfunction

  logic [1:0]   state_q;
  logic [127:0] blk_q;
  logic [3:0]   cnt_q;
  logic [3:0]   nr_q;
  logic         dec_q;
  logic         bad_q;

  logic [127:0] rk [16];
  logic         nr_legal;
  logic [3:0]   nr_in;
  logic         dec_in;
  logic         dec_act;
  logic [3:0]   key_idx;
  logic [127:0] init_blk;
  logic [127:0] enc_next;
  logic [127:0] dec_next;

  // Slot 15 is never addressed; it only keeps every 4-bit index in range.
  always_comb begin
    for (int i = 0; i < 15; i++) rk[i] = expanded_key[KEY_W-1-128*i -: 128];
    rk[15] = '0;
  end

  assign nr_legal = (NR == 4'd10) || (NR == 4'd12) || (NR == 4'd14);
  assign nr_in    = nr_legal ? NR : 4'd14;
  assign dec_in   = (ENABLE_DEC != 0) && i_decrypt;
  assign dec_act  = (ENABLE_DEC != 0) && dec_q;
  assign init_blk = i_data ^ rk[dec_in ? nr_in : 4'd0];
  assign key_idx  = dec_act ? (nr_q - cnt_q) : cnt_q;

  // NOTE: every variable assigned in always_comb gets a value on entry, so no latch can form.
  always_comb begin
    enc_next = sub_shift(blk_q);
    if (cnt_q != nr_q) enc_next = mix_columns(enc_next);
    enc_next = enc_next ^ rk[key_idx];
    dec_next = inv_shift_sub(blk_q) ^ rk[key_idx];
    if (key_idx != 4'd0) dec_next = inv_mix_columns(dec_next);
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      blk_q   <= '0;
      cnt_q   <= '0;
      nr_q    <= '0;
      dec_q   <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_valid) begin
            state_q <= ST_ROUND;
            blk_q   <= init_blk;
            cnt_q   <= 4'd1;
            nr_q    <= nr_in;
            dec_q   <= dec_in;
            bad_q   <= !nr_legal;
          end
        end
        ST_ROUND: begin
          blk_q <= dec_act ? dec_next : enc_next;
          if (cnt_q == nr_q) state_q <= ST_DONE;
          else               cnt_q   <= cnt_q + 4'd1;
        end
        ST_DONE: begin
          if (i_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_ready  = (state_q == ST_IDLE);
  assign o_valid  = (state_q == ST_DONE);
  assign o_data   = blk_q;
  assign o_bad_nr = bad_q && o_valid;

endmodule

// File: tb/tb_aes_iter_core.sv
// Self-checking bench for aes_iter_core: FIPS-197 known answers, backpressure, mid-block
// reset, illegal NR, and random blocks against a table-based AES reference model.
module tb_aes_iter_core;

  localparam int KEY_W = 1920;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_valid;
  logic             o_ready;
  logic [127:0]     i_data;
  logic [3:0]       NR;
  logic             i_decrypt;
  logic [KEY_W-1:0] expanded_key;
  logic             o_valid;
  logic             i_ready;
  logic [127:0]     o_data;
  logic             o_bad_nr;

  int n_checks = 0;
  int n_fail   = 0;

  aes_iter_core dut (
    .clk          (clk),
    .rst          (rst),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_data       (i_data),
    .NR           (NR),
    .i_decrypt    (i_decrypt),
    .expanded_key (expanded_key),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_data       (o_data),
    .o_bad_nr     (o_bad_nr)
  );

  always #5 clk = ~clk;

  // Reference model: GF(2^8) via exp/log tables of generator 3, S-box from the FIPS affine map.
  logic [7:0] gexp  [255];
  logic [7:0] glog  [256];
  logic [7:0] sbox  [256];
  logic [7:0] isbox [256];

  task automatic build_tables();
    logic [7:0] e, inv, q;
    e = 8'h01;
    for (int i = 0; i < 255; i++) begin
      gexp[i] = e;
      glog[e] = i[7:0];
      e = e ^ {e[6:0], 1'b0} ^ (e[7] ? 8'h1b : 8'h00);
    end
    glog[0] = 8'h00;
    for (int x = 0; x < 256; x++) begin
      inv = (x == 0) ? 8'h00 : gexp[(255 - int'(glog[x])) % 255];
      for (int i = 0; i < 8; i++)
        q[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8];
      q = q ^ 8'h63;
      sbox[x]  = q;
      isbox[q] = x[7:0];
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return gexp[(int'(glog[a]) + int'(glog[b])) % 255];
  endfunction

  function automatic logic [127:0] rk_of(input logic [KEY_W-1:0] ek, input int r);
    return ek[KEY_W-1-128*r -: 128];
  endfunction

  function automatic logic [127:0] ref_sub(input logic [127:0] s, input bit inv);
    logic [127:0] o;
    for (int k = 0; k < 16; k++)
      o[127-8*k -: 8] = inv ? isbox[s[127-8*k -: 8]] : sbox[s[127-8*k -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] ref_shift(input logic [127:0] s, input bit inv);
    logic [127:0] o;
    int src;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        src = inv ? (c + 4 - r) % 4 : (c + r) % 4;
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*src) -: 8];
      end
    return o;
  endfunction

  // Column times circulant matrix: row r coefficient for input i is coef[(i-r) mod 4].
  function automatic logic [127:0] ref_mix(input logic [127:0] s, input bit inv);
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    logic [127:0] o;
    if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int i = 0; i < 4; i++)
          acc ^= gmul(coef[(i - r + 4) % 4], s[127-8*(i+4*c) -: 8]);
        o[127-8*(r+4*c) -: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] din, input logic [KEY_W-1:0] ek,
                                           input int nr, input bit dec);
    logic [127:0] s;
    if (!dec) begin
      s = din ^ rk_of(ek, 0);
      for (int r = 1; r <= nr; r++) begin
        s = ref_shift(ref_sub(s, 1'b0), 1'b0);
        if (r < nr) s = ref_mix(s, 1'b0);
        s = s ^ rk_of(ek, r);
      end
    end else begin
      s = din ^ rk_of(ek, nr);
      for (int r = nr - 1; r >= 0; r--) begin
        s = ref_sub(ref_shift(s, 1'b1), 1'b1) ^ rk_of(ek, r);
        if (r > 0) s = ref_mix(s, 1'b1);
      end
    end
    return s;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  // Key schedule; round keys past round nk+6 are filled with noise (don't-care to the core).
  function automatic logic [KEY_W-1:0] expand(input logic [255:0] key, input int nk);
    logic [31:0]      w [60];
    logic [31:0]      tmp;
    logic [7:0]       rc;
    logic [KEY_W-1:0] ek;
    int               nwords;
    nwords = 4 * (nk + 7);
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < nwords; i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = sub_word(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int i = 0; i < 60; i++)
      ek[KEY_W-1-32*i -: 32] = (i < nwords) ? w[i] : $urandom;
    return ek;
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic accept(input logic [127:0] din, input logic [3:0] nr, input logic dec,
                        input logic [KEY_W-1:0] ek);
    int n;
    n = 0;
    i_data = din; NR = nr; i_decrypt = dec; expanded_key = ek; i_valid = 1'b1;
    while (!o_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!o_ready) check("ready_timeout", 128'(o_ready), 128'(1));
    @(posedge clk); #1;
    // Scramble the sampled-once inputs to prove they are only taken at acceptance.
    i_valid = 1'b0;
    i_data = {$urandom, $urandom, $urandom, $urandom};
    NR = 4'($urandom);
    i_decrypt = 1'($urandom);
  endtask

  task automatic run_block(input string name, input logic [127:0] din, input logic [3:0] nr,
                           input logic dec, input logic [KEY_W-1:0] ek, input logic [127:0] exp,
                           input logic exp_bad, input int exp_lat, input int stall, input bit pulse);
    int           lat;
    logic [127:0] first;
    accept(din, nr, dec, ek);
    lat = 0;
    while (!o_valid && lat < 40) begin
      i_valid = pulse && (lat == 3);
      @(posedge clk); #1;
      i_valid = 1'b0;
      lat++;
      if (pulse && lat == 4) check({name, "_ready_in_round"}, 128'(o_ready), 128'(0));
    end
    check({name, "_lat"}, 128'(lat), 128'(exp_lat));
    check({name, "_data"}, o_data, exp);
    check({name, "_bad"}, 128'(o_bad_nr), 128'(exp_bad));
    first = o_data;
    for (int k = 0; k < stall; k++) begin
      i_valid = pulse && (k == 2);
      @(posedge clk); #1;
      i_valid = 1'b0;
      check({name, "_hold_data"}, o_data, first);
      check({name, "_hold_valid"}, 128'(o_valid), 128'(1));
      check({name, "_hold_ready"}, 128'(o_ready), 128'(0));
    end
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
    check({name, "_valid_drop"}, 128'(o_valid), 128'(0));
    check({name, "_ready_back"}, 128'(o_ready), 128'(1));
    if (pulse) begin
      @(posedge clk); #1;
      check({name, "_no_accept"}, 128'(o_ready), 128'(1));
    end
  endtask

  typedef struct {
    logic [255:0] key;
    int           nk;
    logic [3:0]   nr;
    logic         dec;
    logic [127:0] din;
    logic [127:0] dout;
    logic         bad;
  } vec_t;

  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  initial begin
    vec_t             vecs [7];
    logic [KEY_W-1:0] ek;
    logic [3:0]       illegal [6];
    logic [255:0]     key;
    logic [127:0]     din, exp;
    logic [3:0]       nr;
    logic             dec, bad;
    int               nk, nr_eff;

    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_data = '0; NR = '0; i_decrypt = 1'b0;
    expanded_key = '0;
    build_tables();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 128'(o_ready), 128'(1));
    check("rst_valid", 128'(o_valid), 128'(0));
    check("rst_data", o_data, 128'h0);
    check("rst_bad", 128'(o_bad_nr), 128'(0));
    rst = 1'b0;

    vecs[0] = '{KEY128, 4, 4'd10, 1'b0, PT, CT128, 1'b0};
    vecs[1] = '{KEY192, 6, 4'd12, 1'b0, PT, CT192, 1'b0};
    vecs[2] = '{KEY256, 8, 4'd14, 1'b0, PT, CT256, 1'b0};
    vecs[3] = '{KEY128, 4, 4'd10, 1'b1, CT128, PT, 1'b0};
    vecs[4] = '{KEY192, 6, 4'd12, 1'b1, CT192, PT, 1'b0};
    vecs[5] = '{KEY256, 8, 4'd14, 1'b1, CT256, PT, 1'b0};
    vecs[6] = '{KEY256, 8, 4'd7,  1'b0, PT, CT256, 1'b1};
    for (int i = 0; i < 7; i++) begin
      ek = expand(vecs[i].key, vecs[i].nk);
      run_block($sformatf("kat%0d", i), vecs[i].din, vecs[i].nr, vecs[i].dec, ek, vecs[i].dout,
                vecs[i].bad, vecs[i].bad ? 14 : int'(vecs[i].nr), 0, 1'b0);
    end

    // Backpressure with i_valid pulses during ROUND and DONE.
    run_block("bp", PT, 4'd10, 1'b0, expand(KEY128, 4), CT128, 1'b0, 10, 5, 1'b1);

    // Reset while round 6 of an AES-256 block is pending.
    accept(PT, 4'd14, 1'b0, expand(KEY256, 8));
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_ready", 128'(o_ready), 128'(1));
    check("midrst_valid", 128'(o_valid), 128'(0));
    check("midrst_data", o_data, 128'h0);
    check("midrst_bad", 128'(o_bad_nr), 128'(0));
    run_block("after_rst", PT, 4'd10, 1'b0, expand(KEY128, 4), CT128, 1'b0, 10, 0, 1'b0);

    illegal = '{4'd0, 4'd5, 4'd7, 4'd11, 4'd13, 4'd15};
    for (int i = 0; i < 30; i++) begin
      nk  = 4 + 2 * int'($urandom_range(0, 2));
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      ek  = expand(key, nk);
      din = {$urandom, $urandom, $urandom, $urandom};
      dec = 1'($urandom);
      bad = ($urandom_range(0, 7) == 0);
      nr  = bad ? illegal[$urandom_range(0, 5)] : 4'(nk + 6);
      nr_eff = bad ? 14 : nk + 6;
      exp = aes_ref(din, ek, nr_eff, dec);
      run_block($sformatf("rand%0d", i), din, nr, dec, ek, exp, bad, nr_eff,
                int'($urandom_range(0, 3)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
